dc_remove_mc: RTL and testbench

- Multi-channel, parametrised ADC DC-offset canceller for the ADS42 capture path.
- Per channel, a leaky-integrator DC estimate is maintained: dc += (x - dc)*k. The block outputs the corrected sample x - dc.
- Acquisition uses a fast fixed coefficient, then switches to a programmable tracking coefficient. The block supports freeze and clear.
- Sits between the ADC deinterleave logic and downstream DSP. Pure fabric implementation; no vendor mult-add IP.

---
 rtl/dc_remove_mc.sv | 151 +++++++++++++++
 tb/tb_dc_remove_mc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_remove_mc.sv
// dc_remove_mc: per-channel leaky-integrator ADC DC-offset canceller.
// Acquisition runs a fixed fast coefficient; tracking uses k_coef.
module dc_remove_mc #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 2,
  parameter int FRAC_BITS   = 16,
  parameter int K_WIDTH     = 16,
  parameter int ACQ_SAMPLES = 1024,
  parameter int ACQ_SHIFT   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [K_WIDTH-1:0]             k_coef,
  input  logic                           freeze,
  input  logic                           clear,
  output logic                           out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [CHANNELS*DATA_WIDTH-1:0] dc_est,
  output logic                           settled
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + FRAC_BITS;
  localparam int EW = DATA_WIDTH + 1;
  localparam int KW = FRAC_BITS;
  localparam int PW = EW + KW + 1;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(ACQ_SAMPLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(ACQ_SAMPLES - 1);
  localparam logic [KW-1:0] KK_ACQ = KW'(1) << (FRAC_BITS - ACQ_SHIFT);
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

  if (K_WIDTH > FRAC_BITS) begin : g_bad_k
    $error("dc_remove_mc: K_WIDTH must not exceed FRAC_BITS");
  end

  typedef enum logic [1:0] {
    S_ACQ   = 2'd0,
    S_TRACK = 2'd1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_upd;

  assign w_upd   = in_valid & ~freeze & ~clear;
  assign settled = (r_state == S_TRACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACQ;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = S_ACQ;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_ACQ: begin
          if (w_upd) begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CNT_LAST)
              w_state_nxt = S_TRACK;
          end
        end
        S_TRACK: w_state_nxt = S_TRACK;
        default: begin
          w_state_nxt = S_ACQ;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  logic signed [AW-1:0] r_acc    [CHANNELS];
  logic signed [AW-1:0] w_acc_nxt[CHANNELS];
  logic signed [DW-1:0] w_x      [CHANNELS];
  logic signed [DW-1:0] w_d      [CHANNELS];
  logic signed [EW-1:0] w_err    [CHANNELS];
  logic signed [PW-1:0] w_prod   [CHANNELS];
  logic signed [SW-1:0] w_sum    [CHANNELS];
  logic [CHANNELS*DW-1:0] w_y;
  logic [CHANNELS*DW-1:0] w_dc;
  logic [CHANNELS*DW-1:0] r_out;
  logic                   r_ov;
  logic [KW-1:0]          w_kk;

  assign w_kk = settled ? KW'(k_coef) : KK_ACQ;

  always_comb begin
    w_y  = '0;
    w_dc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_x[c] = $signed(in_data[c*DW +: DW]);
      // Floor of acc / 2^FRAC_BITS is just its upper slice.
      w_d[c] = $signed(r_acc[c][AW-1:FRAC_BITS]);
      w_err[c] = $signed({w_x[c][DW-1], w_x[c]})
               - $signed({w_d[c][DW-1], w_d[c]});
      if (w_err[c][EW-1] != w_err[c][EW-2])
        w_y[c*DW +: DW] = w_err[c][EW-1] ? Y_MIN : Y_MAX;
      else
        w_y[c*DW +: DW] = w_err[c][DW-1:0];
      w_prod[c] = PW'(w_err[c]) * PW'($signed({1'b0, w_kk}));
      w_sum[c]  = SW'(r_acc[c]) + SW'(w_prod[c]);
      if (w_sum[c][SW-1:AW-1] == '0 || w_sum[c][SW-1:AW-1] == '1)
        w_acc_nxt[c] = w_sum[c][AW-1:0];
      else
        w_acc_nxt[c] = w_sum[c][SW-1] ? ACC_MIN : ACC_MAX;
      w_dc[c*DW +: DW] = w_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov  <= 1'b0;
      r_out <= '0;
      for (int c = 0; c < CHANNELS; c++)
        r_acc[c] <= '0;
    end else begin
      r_ov <= in_valid;
      if (in_valid)
        r_out <= w_y;
      for (int c = 0; c < CHANNELS; c++) begin
        if (clear)
          r_acc[c] <= '0;
        else if (w_upd)
          r_acc[c] <= w_acc_nxt[c];
      end
    end
  end

  assign out_valid = r_ov;
  assign out_data  = r_out;
  assign dc_est    = w_dc;

endmodule

// File: tb/tb_dc_remove_mc.sv
// tb_dc_remove_mc: directed bench with an arithmetic reference model.
// Model is compared every negedge; literal checks pin key values.
`timescale 1ns/1ps
module tb_dc_remove_mc;
  localparam int DW   = 16;
  localparam int CH   = 2;
  localparam int FB   = 16;
  localparam int ACQN = 8;
  localparam int ACQS = 2;
  localparam longint AMAX = (longint'(1) << 31) - 1;
  localparam longint AMIN = -(longint'(1) << 31);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic freeze = 1'b0;
  logic clear = 1'b0;
  logic [CH*DW-1:0] in_data = '0;
  logic [15:0] k_coef = '0;
  logic out_valid;
  logic [CH*DW-1:0] out_data;
  logic [CH*DW-1:0] dc_est;
  logic settled;

  int n_checks = 0;
  int n_fail = 0;

  dc_remove_mc #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .FRAC_BITS  (FB),
    .K_WIDTH    (16),
    .ACQ_SAMPLES(ACQN),
    .ACQ_SHIFT  (ACQS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .k_coef   (k_coef),
    .freeze   (freeze),
    .clear    (clear),
    .out_valid(out_valid),
    .out_data (out_data),
    .dc_est   (dc_est),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0))
      q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input longint lo,
                                   input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic longint chv(input logic [CH*DW-1:0] v, input int c);
    logic signed [DW-1:0] s;
    s = v[c*DW +: DW];
    return longint'(s);
  endfunction

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkb(input string nm, input logic act, input logic exp);
    check(nm, longint'(act), longint'(exp));
  endtask

  task automatic near(input string nm, input longint act,
                      input longint exp, input longint tol);
    n_checks++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  // Reference model: DC estimate as an exact integer scaled by 2^FB.
  longint m_acc[CH];
  longint m_out[CH];
  logic   m_ov = 1'b0;
  logic   m_settled = 1'b0;
  int     m_cnt = 0;
  bit     m_live = 1'b0;

  function automatic longint mdc(input int c);
    return fdiv(m_acc[c], longint'(1) << FB);
  endfunction

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_out[c] = 0;
    end
    forever begin
      @(posedge clk);
      m_live = 1'b1;
      if (rst) begin
        for (int c = 0; c < CH; c++) begin
          m_acc[c] = 0;
          m_out[c] = 0;
        end
        m_ov = 1'b0;
        m_settled = 1'b0;
        m_cnt = 0;
      end else begin
        longint x, err, kk;
        kk = m_settled ? longint'(k_coef) : (longint'(1) << (FB - ACQS));
        m_ov = in_valid;
        for (int c = 0; c < CH; c++) begin
          x = chv(in_data, c);
          err = x - mdc(c);
          if (in_valid)
            m_out[c] = clamp(err, -32768, 32767);
          if (in_valid && !freeze && !clear)
            m_acc[c] = clamp(m_acc[c] + err * kk, AMIN, AMAX);
        end
        if (clear) begin
          for (int c = 0; c < CH; c++)
            m_acc[c] = 0;
          m_cnt = 0;
          m_settled = 1'b0;
        end else if (in_valid && !freeze && !m_settled) begin
          m_cnt++;
          if (m_cnt == ACQN)
            m_settled = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        checkb("model out_valid", out_valid, m_ov);
        checkb("model settled", settled, m_settled);
        for (int c = 0; c < CH; c++) begin
          check($sformatf("model out_data ch%0d", c),
                chv(out_data, c), m_out[c]);
          check($sformatf("model dc_est ch%0d", c),
                chv(dc_est, c), mdc(c));
        end
      end
    end
  end

  task automatic step(input logic v, input int x0, input int x1);
    in_valid = v;
    in_data  = {x1[15:0], x0[15:0]};
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint d0;
    step(1'b0, 0, 0);
    step(1'b1, 77, 77);
    checkb("reset out_valid", out_valid, 1'b0);
    check("reset out_data", longint'(out_data), 0);
    check("reset dc_est", longint'(dc_est), 0);
    checkb("reset settled", settled, 1'b0);
    rst = 1'b0;

    step(1'b1, 1000, 0);
    check("acq y1", chv(out_data, 0), 1000);
    check("acq dc1", chv(dc_est, 0), 250);
    step(1'b1, 1000, 0);
    check("acq y2", chv(out_data, 0), 750);
    check("acq dc2", chv(dc_est, 0), 437);
    step(1'b1, 1000, 0);
    check("acq y3", chv(out_data, 0), 563);
    check("acq ch1 dc", chv(dc_est, 1), 0);

    for (int i = 4; i <= ACQN; i++) begin
      step(1'b0, 1000, 0);
      checkb("gap out_valid", out_valid, 1'b0);
      checkb("gap settled", settled, 1'b0);
      step(1'b1, 1000, 0);
      checkb("valid out_valid", out_valid, 1'b1);
      checkb($sformatf("settled after %0d", i), settled, (i == ACQN));
    end

    k_coef = 16'h8000;
    repeat (40) step(1'b1, 20000, 0);
    near("settle 20000", chv(dc_est, 0), 20000, 1);
    step(1'b1, -32768, 0);
    check("sat low", chv(out_data, 0), -32768);

    k_coef = 16'h0085;
    d0 = chv(dc_est, 0);
    freeze = 1'b1;
    step(1'b1, 0, 0);
    check("frz dc hold a", chv(dc_est, 0), d0);
    check("frz y a", chv(out_data, 0), 0 - d0);
    step(1'b1, 5000, 0);
    check("frz dc hold b", chv(dc_est, 0), d0);
    check("frz y b", chv(out_data, 0), 5000 - d0);
    freeze = 1'b0;
    step(1'b1, 5000, 0);
    checkb("unfrz dc moves", (chv(dc_est, 0) != d0), 1'b1);
    checkb("unfrz settled", settled, 1'b1);

    d0 = chv(dc_est, 0);
    clear = 1'b1;
    step(1'b1, 7000, 0);
    clear = 1'b0;
    check("clr dc", chv(dc_est, 0), 0);
    checkb("clr settled", settled, 1'b0);
    check("clr y old dc", chv(out_data, 0), 7000 - d0);
    step(1'b1, 100, 0);
    check("post clr y", chv(out_data, 0), 100);
    check("post clr dc", chv(dc_est, 0), 25);

    rst = 1'b1;
    step(1'b1, 1234, -1234);
    rst = 1'b0;
    checkb("mid rst out_valid", out_valid, 1'b0);
    check("mid rst out_data", longint'(out_data), 0);
    check("mid rst dc_est", longint'(dc_est), 0);
    checkb("mid rst settled", settled, 1'b0);

    k_coef = 16'h4000;
    repeat (80) step(1'b1, 3000, -3000);
    near("indep ch0", chv(dc_est, 0), 3000, 1);
    near("indep ch1", chv(dc_est, 1), -3000, 1);

    step(1'b0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
